// File: rtl/snoop_bus_arbiter_if.sv
// Snooping-bus bundle between the arbiter (master) and the caches plus shared memory (slave).
interface snoop_bus_arbiter_if #(
    parameter int NREQ   = 3,
    parameter int TAG_W  = 12,
    parameter int DATA_W = 16
);
    logic [NREQ-1:0]        req;
    logic [2*NREQ-1:0]      req_cmd;
    logic [TAG_W*NREQ-1:0]  req_tag;
    logic [NREQ-1:0]        gnt;
    logic                   bus_valid;
    logic [1:0]             bus_cmd;
    logic [TAG_W-1:0]       bus_tag;
    logic [NREQ-1:0]        snoop_ack;
    logic [NREQ-1:0]        snoop_abort;
    logic [DATA_W*NREQ-1:0] snoop_data;
    logic                   mem_rd;
    logic                   mem_wr;
    logic [TAG_W-1:0]       mem_tag;
    logic [DATA_W-1:0]      mem_wdata;
    logic [DATA_W-1:0]      mem_rdata;
    logic                   mem_ready;
    logic                   fill_valid;
    logic [DATA_W-1:0]      fill_data;
    logic                   fill_from_cache;
    logic                   done;

    modport master (
        input  req, req_cmd, req_tag, snoop_ack, snoop_abort, snoop_data, mem_rdata, mem_ready,
        output gnt, bus_valid, bus_cmd, bus_tag, mem_rd, mem_wr, mem_tag, mem_wdata,
               fill_valid, fill_data, fill_from_cache, done
    );

    modport slave (
        output req, req_cmd, req_tag, snoop_ack, snoop_abort, snoop_data, mem_rdata, mem_ready,
        input  gnt, bus_valid, bus_cmd, bus_tag, mem_rd, mem_wr, mem_tag, mem_wdata,
               fill_valid, fill_data, fill_from_cache, done
    );
endinterface

// File: rtl/snoop_bus_arbiter.sv
// Round-robin snooping-bus arbiter: grant, broadcast, collect snoops, then fill from owner cache or memory.
module snoop_bus_arbiter #(
    parameter int NREQ          = 3,
    parameter int TAG_W         = 12,
    parameter int DATA_W        = 16,
    parameter int SNOOP_TIMEOUT = 15
) (
    input logic                 clock,
    input logic                 reset,
    snoop_bus_arbiter_if.master bus
);
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = $clog2(SNOOP_TIMEOUT + 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] BCAST = 3'd1;
    localparam logic [2:0] SNOOP = 3'd2;
    localparam logic [2:0] MEM   = 3'd3;
    localparam logic [2:0] WB    = 3'd4;
    localparam logic [2:0] FILL  = 3'd5;

    localparam logic [1:0] CMD_INVAL = 2'b10;

    logic [2:0]        state;
    logic [PTR_W-1:0]  rrPtr;
    logic [PTR_W-1:0]  winner;
    logic [NREQ-1:0]   gnt;
    logic [1:0]        busCmd;
    logic [TAG_W-1:0]  busTag;
    logic [CNT_W-1:0]  snoopCnt;
    logic [DATA_W-1:0] wbData;
    logic [DATA_W-1:0] fillData;
    logic              fillFromCache;

    logic [PTR_W-1:0]  pick;
    logic [PTR_W-1:0]  idx;
    logic [PTR_W-1:0]  owner;
    logic              ownerFound;
    logic              acksDone;
    logic              snoopExpired;

    // Descending scan so the offset-0 slot (rrPtr itself) is assigned last and wins.
    always_comb begin
        pick = rrPtr;
        idx  = '0;
        for (int unsigned i = NREQ; i > 0; i--) begin
            idx = PTR_W'((32'(rrPtr) + i - 1) % NREQ);
            if (bus.req[idx]) pick = idx;
        end
    end

    always_comb begin
        owner      = '0;
        ownerFound = 1'b0;
        for (int unsigned i = NREQ; i > 0; i--) begin
            if (bus.snoop_abort[i-1] && !gnt[i-1]) begin
                owner      = PTR_W'(i - 1);
                ownerFound = 1'b1;
            end
        end
    end

    assign acksDone     = &(bus.snoop_ack | gnt);
    assign snoopExpired = (snoopCnt == CNT_W'(SNOOP_TIMEOUT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            rrPtr         <= '0;
            winner        <= '0;
            gnt           <= '0;
            busCmd        <= '0;
            busTag        <= '0;
            snoopCnt      <= '0;
            wbData        <= '0;
            fillData      <= '0;
            fillFromCache <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        winner <= pick;
                        gnt    <= NREQ'(1) << pick;
                        busCmd <= bus.req_cmd[2*pick +: 2];
                        busTag <= bus.req_tag[TAG_W*pick +: TAG_W];
                        state  <= BCAST;
                    end
                end
                BCAST: begin
                    snoopCnt <= '0;
                    state    <= SNOOP;
                end
                SNOOP: begin
                    // A timeout is treated exactly like full acks with no owner.
                    if (acksDone || snoopExpired) begin
                        if (busCmd == CMD_INVAL) begin
                            fillData      <= '0;
                            fillFromCache <= 1'b0;
                            state         <= FILL;
                        end else if (acksDone && ownerFound) begin
                            wbData <= bus.snoop_data[DATA_W*owner +: DATA_W];
                            state  <= WB;
                        end else begin
                            state <= MEM;
                        end
                    end else begin
                        snoopCnt <= snoopCnt + 1'b1;
                    end
                end
                WB: begin
                    fillData      <= wbData;
                    fillFromCache <= 1'b1;
                    state         <= FILL;
                end
                MEM: begin
                    if (bus.mem_ready) begin
                        fillData      <= bus.mem_rdata;
                        fillFromCache <= 1'b0;
                        state         <= FILL;
                    end
                end
                FILL: begin
                    gnt   <= '0;
                    rrPtr <= (32'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt             = gnt;
    assign bus.bus_valid       = (state == BCAST);
    assign bus.bus_cmd         = busCmd;
    assign bus.bus_tag         = busTag;
    assign bus.mem_rd          = (state == MEM);
    assign bus.mem_wr          = (state == WB);
    assign bus.mem_tag         = busTag;
    assign bus.mem_wdata       = (state == WB) ? wbData : '0;
    assign bus.fill_valid      = (state == FILL) && (busCmd != CMD_INVAL);
    assign bus.fill_data       = fillData;
    assign bus.fill_from_cache = fillFromCache;
    assign bus.done            = (state == FILL);
endmodule
